// File: rtl/nsb_evt_pkg.sv
// Shared definitions for the NeXT Sound Box event arbiter: source codes,
// FSM state encoding, event word layout and the round-robin pick helper.
package nsb_evt_pkg;

    // Source codes carried in evt_word[31:30]
    localparam logic [1:0] SRC_KC   = 2'd0;
    localparam logic [1:0] SRC_VOL  = 2'd1;
    localparam logic [1:0] SRC_MUTE = 2'd2;
    localparam logic [1:0] SRC_STAT = 2'd3;
    localparam int         NUM_SRC  = 4;

    // Event word layout
    localparam int EVT_SRC_LSB   = 30;
    localparam int EVT_SEQ_LSB   = 28;
    localparam int EVT_PAYLOAD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_PRESENT = 2'd2
    } arb_state_e;

    // First requesting source at or after ptr, wrapping modulo NUM_SRC.
    // Returns ptr when nothing requests; callers only use it with a request.
    function automatic logic [1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                           input logic [1:0]         ptr);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/nsb_sync_fifo.sv
// Small first-word-fall-through FIFO for keycodes. The head entry is visible
// combinationally so the arbiter can load it in the same cycle it pops.
// A push into a full FIFO is accepted only when a pop happens in that cycle.
module nsb_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk27,
    input  logic         po_reset_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int               AW       = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk27) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk27 or negedge po_reset_n) begin
        if (!po_reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/nsb_event_arbiter.sv
// Collects Sound Box status events (keycodes, volume, mute, video status),
// arbitrates them round-robin into one 32-bit event word for CPU PIO input,
// and holds each word until the CPU toggles its ack bit.
module nsb_event_arbiter
    import nsb_evt_pkg::*;
#(
    parameter int KC_DEPTH = 4,
    parameter int KC_W     = 16,
    parameter int VOL_W    = 12
) (
    input  logic             clk27,
    input  logic             po_reset_n,
    input  logic             kc_valid,
    input  logic [KC_W-1:0]  kc_data,
    input  logic             vol_valid,
    input  logic [VOL_W-1:0] vol_data,
    input  logic             muted,
    input  logic [1:0]       stat_in,
    input  logic             ack_tgl,
    input  logic             clr_ovf,
    output logic [31:0]      evt_word,
    output logic             evt_pending,
    output logic             kc_overflow
);

    arb_state_e r_state;
    arb_state_e w_state_next;

    logic [1:0]       r_rr_ptr;
    logic [1:0]       r_seq;
    logic [31:0]      r_evt_word;
    logic             r_evt_pending;
    logic             r_kc_overflow;
    logic [VOL_W-1:0] r_vol_data;
    logic             r_vol_pend;
    logic             r_mute_pend;
    logic             r_stat_pend;
    logic             r_muted_prev;
    logic [1:0]       r_stat_prev;
    logic             r_ack_prev;

    logic [KC_W-1:0]          w_fifo_dout;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic                     w_pop;
    logic                     w_kc_drop;
    logic [NUM_SRC-1:0]       w_req;
    logic                     w_any_req;
    logic [1:0]               w_winner;
    logic                     w_grant;
    logic                     w_mute_chg;
    logic                     w_stat_chg;
    logic                     w_ack_edge;
    logic [EVT_PAYLOAD_W-1:0] w_payload;
    logic [31:0]              w_evt_word;

    nsb_sync_fifo #(
        .DEPTH (KC_DEPTH),
        .W     (KC_W)
    ) u_kc_fifo (
        .clk27      (clk27),
        .po_reset_n (po_reset_n),
        .i_push     (kc_valid),
        .i_din      (kc_data),
        .i_pop      (w_pop),
        .o_dout     (w_fifo_dout),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    assign w_mute_chg = (muted != r_muted_prev);
    assign w_stat_chg = (stat_in != r_stat_prev);
    assign w_ack_edge = (ack_tgl != r_ack_prev);

    assign w_req     = {r_stat_pend, r_mute_pend, r_vol_pend, ~w_fifo_empty};
    // Incoming strobes/changes count as requests so a strobe in IDLE grants next cycle
    assign w_any_req = (|w_req) | kc_valid | vol_valid | w_mute_chg | w_stat_chg;
    assign w_winner  = rr_pick(w_req, r_rr_ptr);

    assign w_pop     = w_grant && (w_winner == SRC_KC);
    // A pop in the same cycle frees a slot, so only an unpaired full push drops
    assign w_kc_drop = kc_valid & w_fifo_full & ~w_pop;

    // Next-state and grant decode for the present/ack handshake
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                w_grant      = 1'b1;
                w_state_next = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (w_ack_edge) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Payload of the winning source; MUTE/STAT are sampled live at grant time
    always_comb begin
        w_payload = '0;
        case (w_winner)
            SRC_KC:   w_payload[KC_W-1:0]  = w_fifo_dout;
            SRC_VOL:  w_payload[VOL_W-1:0] = r_vol_data;
            SRC_MUTE: w_payload[0]         = muted;
            default:  w_payload[1:0]       = stat_in;
        endcase
    end

    // Assemble the event word from source, sequence number and payload
    always_comb begin
        w_evt_word                          = '0;
        w_evt_word[EVT_SRC_LSB +: 2]        = w_winner;
        w_evt_word[EVT_SEQ_LSB +: 2]        = r_seq;
        w_evt_word[EVT_PAYLOAD_W-1:0]       = w_payload;
    end

    // FSM state register
    always_ff @(posedge clk27 or negedge po_reset_n) begin
        if (!po_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Output word, round-robin pointer and sequence counter updated on grant
    always_ff @(posedge clk27 or negedge po_reset_n) begin
        if (!po_reset_n) begin
            r_evt_word    <= '0;
            r_evt_pending <= 1'b0;
            r_rr_ptr      <= '0;
            r_seq         <= '0;
        end else begin
            r_evt_pending <= (w_state_next == ST_PRESENT);
            if (w_grant) begin
                r_evt_word <= w_evt_word;
                r_rr_ptr   <= w_winner + 2'd1;
                r_seq      <= r_seq + 2'd1;
            end
        end
    end

    // Per-source pending flags; a new set in the grant cycle beats the clear
    always_ff @(posedge clk27 or negedge po_reset_n) begin
        if (!po_reset_n) begin
            r_vol_data  <= '0;
            r_vol_pend  <= 1'b0;
            r_mute_pend <= 1'b0;
            r_stat_pend <= 1'b0;
        end else begin
            if (vol_valid) begin
                r_vol_data <= vol_data;
                r_vol_pend <= 1'b1;
            end else if (w_grant && (w_winner == SRC_VOL)) begin
                r_vol_pend <= 1'b0;
            end
            if (w_mute_chg) begin
                r_mute_pend <= 1'b1;
            end else if (w_grant && (w_winner == SRC_MUTE)) begin
                r_mute_pend <= 1'b0;
            end
            if (w_stat_chg) begin
                r_stat_pend <= 1'b1;
            end else if (w_grant && (w_winner == SRC_STAT)) begin
                r_stat_pend <= 1'b0;
            end
        end
    end

    // Edge-detector history; ack history tracks in every state so stale edges are ignored
    always_ff @(posedge clk27 or negedge po_reset_n) begin
        if (!po_reset_n) begin
            r_muted_prev <= 1'b1;
            r_stat_prev  <= 2'b00;
            r_ack_prev   <= 1'b0;
        end else begin
            r_muted_prev <= muted;
            r_stat_prev  <= stat_in;
            r_ack_prev   <= ack_tgl;
        end
    end

    // Sticky keycode overflow; a drop in the same cycle as clear keeps it set
    always_ff @(posedge clk27 or negedge po_reset_n) begin
        if (!po_reset_n) begin
            r_kc_overflow <= 1'b0;
        end else if (w_kc_drop) begin
            r_kc_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_kc_overflow <= 1'b0;
        end
    end

    assign evt_word    = r_evt_word;
    assign evt_pending = r_evt_pending;
    assign kc_overflow = r_kc_overflow;

endmodule
